locked_alu_mc: RTL and testbench
================================

Name: locked_alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational 8-bit locked ALU.
- Generalised to WIDTH bits.
- Adds iterative shift/rotate-by-N and a shift-add multiply.
- Adds registered status flags and valid/ready handshakes on input and output.
- Sits between the operand/control path and the accumulator writeback; locking_key bits still gate correct opcode semantics.

Parameters:
- WIDTH, 8, datapath width; power of two, >= 4.
- SAW, $clog2(WIDTH), shift-amount width (derived; do not override).

Ports:
- clk  input  1  single clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept a request this cycle.
- opcode  input  4  operation select.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; b[SAW-1:0] is the shift amount for shift/rotate ops.
- locking_key  input  8  key; bits [3:0] used, [7:4] reserved/ignored.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- y  output  WIDTH  result.
- flag_z  output  1  y == 0.
- flag_c  output  1  carry/borrow/shift-out/overflow.
- flag_n  output  1  y[WIDTH-1].

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; in_ready=1; out_valid=0; y=0; flag_z=0, flag_c=0, flag_n=0. Reset has priority over everything, including mid-operation: any in-flight op is discarded.
- FSM states: IDLE, BUSY, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- Accept: in_valid&&in_ready at edge k. opcode, a, b and locking_key are captured at edge k; later changes are ignored.
- Single-cycle ops (latency L=1): IDLE -> DONE at edge k.
- Multi-cycle ops: IDLE -> BUSY at edge k, BUSY -> DONE after L-1 BUSY cycles. out_valid rises after edge k+L-1, i.e. is visible in cycle k+L.
- DONE: y and flags held stable until out_ready=1; DONE -> IDLE on that edge. Throughput is at most one op per 2 cycles; no same-cycle turnaround.
- Opcodes (key bit = 1 gives the correct op; key bit = 0 gives the corrupted op):
  - 0x0 ADD: {c,y}=a+b. key[0]=0: acts as SUB.
  - 0x1 SUB: y=a-b; c=borrow (a<b).
  - 0x2 AND, 0x3 OR: c=0.
  - 0x4 XOR: c=0. key[1]=0: XNOR.
  - 0x5 SHL, 0x6 SHR, 0x7 ROL, 0x8 ROR:
    - amt=b[SAW-1:0]; one bit position per BUSY cycle.
    - L=amt+1 for amt>=1; amt=0 gives L=1, y=a, c=0.
    - c = last bit shifted or rotated out.
    - key[2]=0: SHL/SHR directions swapped, and ROL/ROR directions swapped.
  - 0x9 INC, 0xA DEC: y=a+-1 modulo 2^WIDTH; c = wrap (INC of all-ones, DEC of 0).
  - 0xB INV: y=~a, c=0.
  - 0xC MUL: y = low WIDTH bits of a*b.
    - Shift-add over a 2*WIDTH accumulator, one multiplier bit per cycle; L=WIDTH+1 regardless of operand values.
    - c=1 iff the high half of the product is nonzero.
    - key[3]=0: y = high half instead of low half.
  - 0xD-0xF CLR: y=0, c=0, L=1.
- Flags: flag_z and flag_n are computed from the final y. All flags are registered together with y.

Optional Feature:
- Macro: LOCKED_ALU_MC_FLUSH_EN.
- Defined: adds input port flush (1 bit).
  - flush=1 at an edge in BUSY or DONE: state -> IDLE; out_valid=0 next cycle; result dropped; y and flags keep their old values.
  - flush in IDLE: no effect; a same-cycle accept still occurs.
  - rst_n still has priority over flush.
- Not defined: no flush port; an operation always runs to DONE.

Test Plan (WIDTH=8, locking_key=8'h0F unless noted):
1. ADD a=8'hF0 b=8'h20 -> y=8'h10, flag_c=1, flag_z=0, flag_n=0; out_valid in cycle k+1. Repeat with key=8'h0E -> y=8'hD0, flag_c=0, flag_n=1.
2. MUL a=15 b=17 -> y=8'hFF, flag_c=0, out_valid in cycle k+9. MUL a=16 b=16 -> y=8'h00, flag_z=1, flag_c=1. With key=8'h07, a=16 b=16 -> y=8'h01.
3. SHL a=8'h81 b=3 -> y=8'h08, flag_c=0, latency 4. ROL a=8'h81 b=1 -> y=8'h03, flag_c=1, latency 2. SHL b=0 -> y=a, latency 1.
4. DEC a=8'h00 -> y=8'hFF, flag_c=1, flag_n=1. XOR a=b=8'h5A with key=8'h0D -> y=8'hFF.
5. Backpressure: result ready, out_ready=0 for 5 cycles while in_valid=1 with a new op -> y/flags/out_valid stable, in_ready=0, no accept. out_ready=1 -> IDLE next cycle, new op accepted the cycle after.
6. rst_n=0 for one edge 3 cycles into a MUL -> out_valid=0, y=0, all flags 0, in_ready=1. A subsequent ADD 1+1 returns y=8'h02.

Source files
------------

// File: rtl/locked_alu_mc.sv
// locked_alu_mc: multi-cycle locked ALU with valid/ready handshakes.
// Shifts and rotates move one bit per BUSY cycle. MUL is a shift-add over a
// 2*WIDTH accumulator. Result and flags are registered together.
// Optional flush input: define LOCKED_ALU_MC_FLUSH_EN.
module locked_alu_mc #(
  parameter int WIDTH = 8,
  parameter int SAW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LOCKED_ALU_MC_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       locking_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_n
);

  localparam int CW = SAW + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic                 is_mul;
  logic                 hi_sel;
  logic                 sh_left;
  logic                 sh_rot;
  logic [WIDTH-1:0]     sh;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;

  logic                 fl;
  logic [SAW-1:0]       amt;
  logic [WIDTH-1:0]     r_y;
  logic                 r_c;
  logic                 multi;
  logic                 op_mul;
  logic                 op_left;
  logic                 op_rot;
  logic [WIDTH-1:0]     s_nxt;
  logic                 s_out;
  logic [WIDTH:0]       m_sum;
  logic [2*WIDTH-1:0]   m_nxt;
  logic [WIDTH-1:0]     f_y;
  logic                 f_c;
  logic                 unused_key;

`ifdef LOCKED_ALU_MC_FLUSH_EN
  assign fl = flush;
`else
  assign fl = 1'b0;
`endif

  // Upper key bits are reserved.
  assign unused_key = ^locking_key[7:4];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign amt       = b[SAW-1:0];

  // Decode the request: single-cycle result, or setup for an iterative op.
  always_comb begin
    r_y     = '0;
    r_c     = 1'b0;
    multi   = 1'b0;
    op_mul  = (opcode == 4'hC);
    op_rot  = (opcode == 4'h7) || (opcode == 4'h8);
    // key[2] low swaps the shift/rotate direction
    op_left = ((opcode == 4'h5) || (opcode == 4'h7)) == locking_key[2];
    case (opcode)
      4'h0: begin
        if (locking_key[0]) {r_c, r_y} = {1'b0, a} + {1'b0, b};
        else                {r_c, r_y} = {1'b0, a} - {1'b0, b};
      end
      4'h1: {r_c, r_y} = {1'b0, a} - {1'b0, b};
      4'h2: r_y = a & b;
      4'h3: r_y = a | b;
      4'h4: r_y = locking_key[1] ? (a ^ b) : ~(a ^ b);
      4'h5, 4'h6, 4'h7, 4'h8: begin
        if (amt == '0) r_y = a;
        else           multi = 1'b1;
      end
      4'h9: begin
        r_y = a + WIDTH'(1);
        r_c = &a;
      end
      4'hA: begin
        r_y = a - WIDTH'(1);
        r_c = ~|a;
      end
      4'hB: r_y = ~a;
      4'hC: multi = 1'b1;
      default: begin
        r_y = '0;
        r_c = 1'b0;
      end
    endcase
  end

  // One iteration step of the shifter and the multiplier, plus final result.
  always_comb begin
    if (sh_left) begin
      s_out = sh[WIDTH-1];
      s_nxt = {sh[WIDTH-2:0], sh_rot & sh[WIDTH-1]};
    end else begin
      s_out = sh[0];
      s_nxt = {sh_rot & sh[0], sh[WIDTH-1:1]};
    end
    m_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + ({(WIDTH+1){acc[0]}} & {1'b0, mcand});
    m_nxt = {m_sum, acc[WIDTH-1:1]};
    if (is_mul) begin
      f_y = hi_sel ? m_nxt[2*WIDTH-1:WIDTH] : m_nxt[WIDTH-1:0];
      f_c = |m_nxt[2*WIDTH-1:WIDTH];
    end else begin
      f_y = s_nxt;
      f_c = s_out;
    end
  end

  // Control FSM with iteration registers and registered result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      y       <= '0;
      flag_z  <= 1'b0;
      flag_c  <= 1'b0;
      flag_n  <= 1'b0;
      is_mul  <= 1'b0;
      hi_sel  <= 1'b0;
      sh_left <= 1'b0;
      sh_rot  <= 1'b0;
      sh      <= '0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (multi) begin
              state   <= BUSY;
              is_mul  <= op_mul;
              hi_sel  <= ~locking_key[3];
              sh_left <= op_left;
              sh_rot  <= op_rot;
              sh      <= a;
              mcand   <= a;
              acc     <= {{WIDTH{1'b0}}, b};
              cnt     <= op_mul ? CW'(WIDTH) : {1'b0, amt};
            end else begin
              state  <= DONE;
              y      <= r_y;
              flag_z <= (r_y == '0);
              flag_c <= r_c;
              flag_n <= r_y[WIDTH-1];
            end
          end
        end
        BUSY: begin
          if (fl) begin
            state <= IDLE;
          end else begin
            sh  <= s_nxt;
            acc <= m_nxt;
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              state  <= DONE;
              y      <= f_y;
              flag_z <= (f_y == '0);
              flag_c <= f_c;
              flag_n <= f_y[WIDTH-1];
            end
          end
        end
        DONE: begin
          if (fl || out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_locked_alu_mc.sv
// Self-checking bench for locked_alu_mc (WIDTH=8): directed plan cases,
// randomized ops against a behavioural model, backpressure and reset.
module tb_locked_alu_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] opcode = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] key = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] y;
  logic       flag_z, flag_c, flag_n;
`ifdef LOCKED_ALU_MC_FLUSH_EN
  logic       flush = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  locked_alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef LOCKED_ALU_MC_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .a(a), .b(b), .locking_key(key), .out_valid(out_valid),
    .out_ready(out_ready), .y(y), .flag_z(flag_z), .flag_c(flag_c),
    .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // Reference: result, carry and latency straight from the opcode rules.
  function automatic void model(input logic [3:0] op, input logic [7:0] ia, ib, ik,
                                output logic [7:0] ey, output logic ec, output int lat);
    int amt, ai, s;
    logic left;
    logic [15:0] p;
    amt = int'(ib) % 8;
    ai  = int'(ia);
    lat = 1;
    ec  = 1'b0;
    ey  = 8'h00;
    case (op)
      4'h0: if (ik[0]) begin s = ai + int'(ib); ey = 8'(s); ec = (s > 255); end
            else begin ey = 8'(ai - int'(ib)); ec = (ia < ib); end
      4'h1: begin ey = 8'(ai - int'(ib)); ec = (ia < ib); end
      4'h2: ey = ia & ib;
      4'h3: ey = ia | ib;
      4'h4: ey = ik[1] ? (ia ^ ib) : ~(ia ^ ib);
      4'h5, 4'h6, 4'h7, 4'h8: begin
        if (amt == 0) ey = ia;
        else begin
          lat  = amt + 1;
          left = (op == 4'h5) || (op == 4'h7);
          if (!ik[2]) left = !left;
          if (op >= 4'h7) begin
            if (left) begin ey = 8'((ai << amt) | (ai >> (8 - amt))); ec = ey[0]; end
            else      begin ey = 8'((ai >> amt) | (ai << (8 - amt))); ec = ey[7]; end
          end else begin
            if (left) begin ey = 8'(ai << amt); ec = ia[8 - amt]; end
            else      begin ey = 8'(ai >> amt); ec = ia[amt - 1]; end
          end
        end
      end
      4'h9: begin ey = 8'(ai + 1); ec = (ia == 8'hFF); end
      4'hA: begin ey = 8'(ai - 1); ec = (ia == 8'h00); end
      4'hB: ey = ~ia;
      4'hC: begin
        p   = 16'(ai * int'(ib));
        ey  = ik[3] ? p[7:0] : p[15:8];
        ec  = (p[15:8] != 8'h00);
        lat = 9;
      end
      default: ey = 8'h00;
    endcase
  endfunction

  // Drive one op, scramble inputs after accept, measure latency, pop result.
  task automatic issue(input logic [3:0] op, input logic [7:0] ia, ib, ik,
                       output logic [7:0] oy, output logic oz, oc, on, output int lat);
    int g;
    @(negedge clk);
    g = 0;
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    opcode = op; a = ia; b = ib; key = ik; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom); key = 8'($urandom);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 40);
    oy = y; oz = flag_z; oc = flag_c; on = flag_n;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, y, flag_z, flag_c, flag_n} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset: got rdy=%b vld=%b y=%h zcn=%b%b%b want rdy=1 vld=0 y=00 zcn=000",
               in_ready, out_valid, y, flag_z, flag_c, flag_n);
    end
  endtask

  task automatic test_directed();
    logic [3:0] t_op [10] = '{4'h0, 4'h0, 4'hC, 4'hC, 4'hC, 4'h5, 4'h7, 4'h5, 4'hA, 4'h4};
    logic [7:0] t_a  [10] = '{8'hF0, 8'hF0, 8'd15, 8'd16, 8'd16, 8'h81, 8'h81, 8'h81, 8'h00, 8'h5A};
    logic [7:0] t_b  [10] = '{8'h20, 8'h20, 8'd17, 8'd16, 8'd16, 8'd3, 8'd1, 8'd0, 8'h00, 8'h5A};
    logic [7:0] t_k  [10] = '{8'h0F, 8'h0E, 8'h0F, 8'h0F, 8'h07, 8'h0F, 8'h0F, 8'h0F, 8'h0F, 8'h0D};
    logic [7:0] t_y  [10] = '{8'h10, 8'hD0, 8'hFF, 8'h00, 8'h01, 8'h08, 8'h03, 8'h81, 8'hFF, 8'hFF};
    logic       t_c  [10] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int         t_l  [10] = '{1, 1, 9, 9, 9, 4, 2, 1, 1, 1};
    logic [7:0] oy;
    logic oz, oc, on;
    int lat;
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_a[i], t_b[i], t_k[i], oy, oz, oc, on, lat);
      total++;
      if ({oy, oz, oc, on, 8'(lat)} !== {t_y[i], (t_y[i] == 8'h00), t_c[i], t_y[i][7], 8'(t_l[i])}) begin
        bad++;
        $display("FAIL directed[%0d]: got y=%h zcn=%b%b%b lat=%0d want y=%h c=%b lat=%0d",
                 i, oy, oz, oc, on, lat, t_y[i], t_c[i], t_l[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] oy, ey, ra, rb, rk;
    logic [3:0] rop;
    logic oz, oc, on, ec;
    int lat, elat;
    for (int i = 0; i < 150; i++) begin
      rop = 4'($urandom); ra = 8'($urandom); rb = 8'($urandom); rk = 8'($urandom);
      model(rop, ra, rb, rk, ey, ec, elat);
      issue(rop, ra, rb, rk, oy, oz, oc, on, lat);
      total++;
      if ({oy, oz, oc, on, 8'(lat)} !== {ey, (ey == 8'h00), ec, ey[7], 8'(elat)}) begin
        bad++;
        $display("FAIL random[%0d] op=%h a=%h b=%h k=%h: got y=%h zcn=%b%b%b lat=%0d want y=%h c=%b lat=%0d",
                 i, rop, ra, rb, rk, oy, oz, oc, on, lat, ey, ec, elat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [11:0] held;
    int g;
    logic ok;
    @(negedge clk);
    opcode = 4'h1; a = 8'h03; b = 8'h04; key = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    g = 0;
    do begin @(negedge clk); g++; end while (!out_valid && g < 40);
    held = {out_valid, in_ready, y, flag_z, flag_c};
    total++;
    if (held !== {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL bp_result: got %h want %h", held, {1'b1, 1'b0, 8'hFF, 1'b0, 1'b1});
    end
    opcode = 4'h0; a = 8'd10; b = 8'd20; in_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if ({out_valid, in_ready, y, flag_z, flag_c, flag_n} !== {held, 1'b1}) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL bp_hold: got vld=%b rdy=%b y=%h want stable vld=1 rdy=0 y=ff",
               out_valid, in_ready, y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
    end
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({out_valid, y} !== {1'b1, 8'd30}) begin
      bad++;
      $display("FAIL bp_next: got vld=%b y=%h want vld=1 y=1e", out_valid, y);
    end
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [7:0] oy;
    logic oz, oc, on, quiet;
    int lat;
    @(negedge clk);
    opcode = 4'hC; a = 8'd15; b = 8'd17; key = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({in_ready, out_valid, y, flag_z, flag_c, flag_n} !== {1'b1, 1'b0, 8'h00, 3'b000}) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%b vld=%b y=%h zcn=%b%b%b want rdy=1 vld=0 y=00 zcn=000",
               in_ready, out_valid, y, flag_z, flag_c, flag_n);
    end
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    total++;
    if (!quiet) begin
      bad++;
      $display("FAIL reset_drop: got out_valid=1 after reset want 0");
    end
    issue(4'h0, 8'd1, 8'd1, 8'h0F, oy, oz, oc, on, lat);
    total++;
    if ({oy, oz, oc, on, 8'(lat)} !== {8'h02, 3'b000, 8'd1}) begin
      bad++;
      $display("FAIL reset_add: got y=%h zcn=%b%b%b lat=%0d want y=02 zcn=000 lat=1",
               oy, oz, oc, on, lat);
    end
  endtask

`ifdef LOCKED_ALU_MC_FLUSH_EN
  task automatic test_flush();
    logic [7:0] prev;
    prev = y;
    @(negedge clk);
    opcode = 4'hC; a = 8'd3; b = 8'd5; key = 8'h0F; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if ({in_ready, out_valid, y} !== {1'b1, 1'b0, prev}) begin
      bad++;
      $display("FAIL flush: got rdy=%b vld=%b y=%h want rdy=1 vld=0 y=%h",
               in_ready, out_valid, y, prev);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
`ifdef LOCKED_ALU_MC_FLUSH_EN
    test_flush();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
